// File: rtl/cdc_handshake_src.sv
// Source side of a 4-phase REQ/ACK multi-bit CDC handshake: captures a word,
// holds it on DATA_OUT and drives REQ until the synchronized ACK round trip completes.
module cdc_handshake_src #(
  parameter int unsigned BUS_WIDTH  = 8,
  parameter int unsigned NUM_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [BUS_WIDTH-1:0] SRC_DATA,
  input  logic                 SRC_VALID,
  output logic                 SRC_READY,
  output logic [BUS_WIDTH-1:0] DATA_OUT,
  output logic                 REQ,
  input  logic                 ACK_ASYNC,
  output logic                 DONE,
  output logic                 PROTO_ERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ_HI = 2'd1,
    ACK_LO = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_STAGES-1:0]  sync_q, sync_d;
  logic [BUS_WIDTH-1:0]   data_q, data_d;
  logic                   req_q, req_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   ack_sync;
  logic                   ready;

  assign ack_sync = sync_q[NUM_STAGES-1];
  assign ready    = (state_q == IDLE) && !ack_sync;

  always_comb begin
    sync_d = {sync_q[NUM_STAGES-2:0], ACK_ASYNC};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      sync_q  <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      data_q  <= data_d;
      req_q   <= req_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    req_d   = req_q;
    done_d  = 1'b0;
    // An ACK still high while idle means the destination is out of step.
    err_d   = err_q | ((state_q == IDLE) && ack_sync);
    unique case (state_q)
      IDLE: begin
        if (SRC_VALID && ready) begin
          data_d  = SRC_DATA;
          req_d   = 1'b1;
          state_d = REQ_HI;
        end
      end
      REQ_HI: begin
        if (ack_sync) begin
          req_d   = 1'b0;
          state_d = ACK_LO;
        end
      end
      ACK_LO: begin
        if (!ack_sync) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign SRC_READY = ready;
  assign DATA_OUT  = data_q;
  assign REQ       = req_q;
  assign DONE      = done_q;
  assign PROTO_ERR = err_q;

endmodule

// File: tb/tb_cdc_handshake_src.sv
// Directed bench for cdc_handshake_src; a negedge monitor checks each REQ rise
// and DONE pulse against a queue of words pushed by the stimulus.
module tb_cdc_handshake_src;

  localparam int unsigned NS = 2;

  logic       clk;
  logic       rst;
  logic [7:0] src_data;
  logic       src_valid;
  logic       src_ready;
  logic [7:0] data_out;
  logic       req;
  logic       ack_async;
  logic       done;
  logic       proto_err;

  logic       auto_ack;
  logic       ack_man;

  int n_total = 0;
  int n_pass  = 0;
  int n_done  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] done_q[$];
  logic       prev_req;

  assign ack_async = auto_ack ? req : ack_man;

  cdc_handshake_src #(
    .BUS_WIDTH (8),
    .NUM_STAGES(NS)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .SRC_DATA (src_data),
    .SRC_VALID(src_valid),
    .SRC_READY(src_ready),
    .DATA_OUT (data_out),
    .REQ      (req),
    .ACK_ASYNC(ack_async),
    .DONE     (done),
    .PROTO_ERR(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every new REQ must carry the next queued word; every DONE must
  // retire the word that REQ carried.
  always @(negedge clk) begin
    if (rst) begin
      done_q.delete();
      prev_req = 1'b0;
    end else begin
      if (req && !prev_req) begin
        check("req_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          logic [7:0] w;
          w = exp_q.pop_front();
          check("req_data", 32'(data_out), 32'(w));
          done_q.push_back(w);
        end
      end
      if (done) begin
        n_done++;
        check("done_expected", 32'(done_q.size() != 0), 32'd1);
        if (done_q.size() != 0) begin
          logic [7:0] w;
          w = done_q.pop_front();
          check("done_data", 32'(data_out), 32'(w));
        end
      end
      prev_req = req;
    end
  end

  task automatic xfer(input logic [7:0] d, input int dly, input bit scramble);
    src_data  = d;
    src_valid = 1'b1;
    exp_q.push_back(d);
    check("ready_before_accept", 32'(src_ready), 32'd1);
    tick();
    src_valid = 1'b0;
    check("req_after_accept", 32'(req), 32'd1);
    check("data_after_accept", 32'(data_out), 32'(d));
    check("ready_busy", 32'(src_ready), 32'd0);
    for (int i = 0; i < dly; i++) begin
      if (scramble) begin
        src_valid = 1'b1;
        src_data  = 8'($urandom_range(255));
      end
      tick();
      check("req_wait", 32'(req), 32'd1);
      check("ready_wait", 32'(src_ready), 32'd0);
      check("done_wait", 32'(done), 32'd0);
      check("data_hold_req", 32'(data_out), 32'(d));
    end
    src_valid = 1'b0;
    ack_man   = 1'b1;
    for (int k = 1; k <= int'(NS) + 1; k++) begin
      tick();
      check("req_fall_timing", 32'(req), 32'(k < int'(NS) + 1));
      check("ready_ack_hi", 32'(src_ready), 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      check("req_low_ack_hi", 32'(req), 32'd0);
      check("done_ack_hi", 32'(done), 32'd0);
      check("data_hold_ack", 32'(data_out), 32'(d));
    end
    ack_man = 1'b0;
    for (int k = 1; k <= int'(NS) + 1; k++) begin
      tick();
      check("done_timing", 32'(done), 32'(k == int'(NS) + 1));
      check("ready_return", 32'(src_ready), 32'(k == int'(NS) + 1));
    end
    tick();
    check("done_single", 32'(done), 32'd0);
    check("ready_idle", 32'(src_ready), 32'd1);
    check("data_hold_idle", 32'(data_out), 32'(d));
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    int done_base;

    rst       = 1'b1;
    src_data  = '0;
    src_valid = 1'b0;
    auto_ack  = 1'b0;
    ack_man   = 1'b0;

    tick();
    check("rst_req", 32'(req), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(proto_err), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("ready_after_rst", 32'(src_ready), 32'd1);

    // Basic transfer
    xfer(8'hA5, 3, 1'b0);
    // Data hold while SRC_DATA churns and SRC_VALID stays asserted
    xfer(8'h5A, 3, 1'b1);

    // Back-to-back with an immediate responder
    auto_ack  = 1'b1;
    done_base = n_done;
    src_data  = 8'h01;
    src_valid = 1'b1;
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h02);
    tick();
    check("b2b_req1", 32'(req), 32'd1);
    check("b2b_data1", 32'(data_out), 32'h01);
    src_data = 8'h02;
    wait_done(got);
    check("b2b_done1", 32'(got), 32'd1);
    check("b2b_ready_after_done", 32'(src_ready), 32'd1);
    check("b2b_req_low_at_done", 32'(req), 32'd0);
    tick();
    check("b2b_req2", 32'(req), 32'd1);
    check("b2b_data2", 32'(data_out), 32'h02);
    check("b2b_done_cleared", 32'(done), 32'd0);
    src_valid = 1'b0;
    wait_done(got);
    check("b2b_done2", 32'(got), 32'd1);
    tick();
    tick();
    check("b2b_done_count", 32'(n_done - done_base), 32'd2);
    check("b2b_idle_ready", 32'(src_ready), 32'd1);
    auto_ack = 1'b0;
    tick();

    // Stalled ACK
    xfer(8'hC3, 50, 1'b0);

    // Reset between edges while in REQ_HI
    src_data  = 8'h77;
    src_valid = 1'b1;
    exp_q.push_back(8'h77);
    tick();
    src_valid = 1'b0;
    tick();
    check("pre_rst_req", 32'(req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_req", 32'(req), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_data", 32'(data_out), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_ready", 32'(src_ready), 32'd1);
    check("post_rst_req", 32'(req), 32'd0);

    // Protocol error: ACK high while idle for five cycles
    ack_man = 1'b1;
    tick();
    check("perr_e1_err", 32'(proto_err), 32'd0);
    check("perr_e1_ready", 32'(src_ready), 32'd1);
    tick();
    check("perr_e2_ready", 32'(src_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("perr_set", 32'(proto_err), 32'd1);
      check("perr_ready_low", 32'(src_ready), 32'd0);
      check("perr_no_req", 32'(req), 32'd0);
    end
    ack_man = 1'b0;
    tick();
    check("perr_ready_still_low", 32'(src_ready), 32'd0);
    tick();
    check("perr_ready_back", 32'(src_ready), 32'd1);
    check("perr_sticky", 32'(proto_err), 32'd1);
    xfer(8'h3C, 3, 1'b0);
    check("perr_sticky_end", 32'(proto_err), 32'd1);

    tick();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("done_q_drained", 32'(done_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
